pi_nlevel: RTL and testbench

PI_NLEVEL -- requirements
Module: pi_nlevel

---
 rtl/pi_pkg.sv | 22 ++
 rtl/pi_ffs.sv | 19 +
 rtl/pi_nlevel.sv | 169 ++++++++++++++++
 tb/tb_pi_nlevel.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pi_pkg.sv
// Shared types and constants for the n-level priority interrupt block.
package pi_pkg;

  // Arbitration FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_TEST = 2'd2,
    ST_REQ  = 2'd3
  } pi_state_e;

  // Command word width and bit positions, {sys_clr .. act} MSB first.
  localparam int unsigned CMD_W       = 7;
  localparam int unsigned CMD_ACT     = 0;
  localparam int unsigned CMD_DEACT   = 1;
  localparam int unsigned CMD_ON_CLR  = 2;
  localparam int unsigned CMD_ON_SET  = 3;
  localparam int unsigned CMD_GEN_SET = 4;
  localparam int unsigned CMD_GEN_CLR = 5;
  localparam int unsigned CMD_SYS_CLR = 6;

endpackage

// File: rtl/pi_ffs.sv
// Find-first-set encoder: returns 1 + index of the lowest set bit, 0 if none.
module pi_ffs #(
  parameter int unsigned N = 7
) (
  input  logic [N-1:0]             vec_i,
  output logic [$clog2(N+1)-1:0]   idx_o
);

  localparam int unsigned LW = $clog2(N + 1);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = LW'(i + 1);
    end
  end

endmodule

// File: rtl/pi_nlevel.sv
// N-level priority interrupt controller: per-level enable/software request,
// edge or level device sources, nested hold tracking and a request handshake.
module pi_nlevel
  import pi_pkg::*;
#(
  parameter int unsigned        NLEVELS   = 7,
  parameter logic [NLEVELS-1:0] EDGE_MASK = '0,
  localparam int unsigned       LW        = $clog2(NLEVELS + 1)
) (
  input  logic               clk,
  input  logic               RESET,
  input  logic               cono_stb,
  input  logic [CMD_W-1:0]   cono_cmd,
  input  logic [NLEVELS-1:0] cono_lvl,
  input  logic [NLEVELS-1:0] io_req,
  input  logic               pi_disable,
  output logic               req,
  output logic [LW-1:0]      req_lvl,
  input  logic               grant,
  input  logic               dismiss,
  output logic [NLEVELS-1:0] pih,
  output logic [NLEVELS-1:0] on,
  output logic [NLEVELS-1:0] gen,
  output logic               active,
  output logic [LW-1:0]      hold_lvl
);

  pi_state_e          state_q, state_d;
  logic               cono_dly_q;
  logic [CMD_W-1:0]   cmd_q;
  logic [NLEVELS-1:0] lvl_q;
  logic [NLEVELS-1:0] on_q, on_d, gen_q, gen_d, pih_q, pih_d;
  logic [NLEVELS-1:0] pir_q, pir_d, pend_q, pend_d, prev_q;
  logic               active_q, active_d, req_q, req_d;
  logic [LW-1:0]      req_lvl_q, req_lvl_d;
  logic [LW-1:0]      pir_lvl, hold_lvl_w, elig_lvl;
  logic               grant_ok;
  logic               c_sys, c_gen_clr, c_gen_set, c_on_set, c_on_clr, c_deact, c_act;
  logic [NLEVELS-1:0] src, grant_mask, dismiss_mask, pend_set, pend_clr;

  // Command bits qualified by the delayed strobe.
  assign c_sys     = cono_dly_q & cmd_q[CMD_SYS_CLR];
  assign c_gen_clr = cono_dly_q & cmd_q[CMD_GEN_CLR];
  assign c_gen_set = cono_dly_q & cmd_q[CMD_GEN_SET];
  assign c_on_set  = cono_dly_q & cmd_q[CMD_ON_SET];
  assign c_on_clr  = cono_dly_q & cmd_q[CMD_ON_CLR];
  assign c_deact   = cono_dly_q & cmd_q[CMD_DEACT];
  assign c_act     = cono_dly_q & cmd_q[CMD_ACT];

  pi_ffs #(.N(NLEVELS)) u_ffs_pir  (.vec_i(pir_q), .idx_o(pir_lvl));
  pi_ffs #(.N(NLEVELS)) u_ffs_hold (.vec_i(pih_q), .idx_o(hold_lvl_w));

  // Lowest requesting level is eligible only if it outranks every held level.
  assign elig_lvl = ((pir_lvl != '0) && ((hold_lvl_w == '0) || (pir_lvl < hold_lvl_w)))
                    ? pir_lvl : '0;

  assign grant_mask   = grant_ok ? (NLEVELS'(1) << (req_lvl_q - LW'(1))) : '0;
  assign dismiss_mask = (dismiss && (hold_lvl_w != '0))
                        ? (NLEVELS'(1) << (hold_lvl_w - LW'(1))) : '0;

  assign src      = (EDGE_MASK & pend_q) | (~EDGE_MASK & io_req);
  assign pend_set = EDGE_MASK & io_req & ~prev_q;
  assign pend_clr = grant_mask | (c_on_clr ? lvl_q : '0);

  // FSM state register.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state, request handshake and abort handling.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    req_lvl_d = req_lvl_q;
    grant_ok  = 1'b0;
    unique case (state_q)
      ST_IDLE: state_d = ST_LOAD;
      ST_LOAD: state_d = ST_TEST;
      ST_TEST: begin
        if ((elig_lvl != '0) && !pi_disable && !cono_dly_q) begin
          state_d   = ST_REQ;
          req_d     = 1'b1;
          req_lvl_d = elig_lvl;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (cono_stb || pi_disable) begin
          state_d   = ST_IDLE;
          req_d     = 1'b0;
          req_lvl_d = '0;
        end else if (grant) begin
          grant_ok  = 1'b1;
          state_d   = ST_IDLE;
          req_d     = 1'b0;
          req_lvl_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Level state update: clear-before-set, pending latch, hold stack, snapshot.
  always_comb begin
    on_d     = on_q;
    gen_d    = gen_q;
    active_d = active_q;
    if (c_on_clr)  on_d  = on_d & ~lvl_q;
    if (c_on_set)  on_d  = on_d | lvl_q;
    if (c_gen_clr) gen_d = gen_d & ~lvl_q;
    if (c_gen_set) gen_d = gen_d | lvl_q;
    if (c_deact)   active_d = 1'b0;
    if (c_act)     active_d = 1'b1;
    pih_d  = (pih_q & ~dismiss_mask) | grant_mask;
    pend_d = (pend_q & ~pend_clr) | pend_set;
    pir_d  = pir_q;
    if (state_q == ST_LOAD) pir_d = {NLEVELS{active_d}} & (gen_d | (on_d & src));
    if (c_sys) begin
      on_d     = '0;
      gen_d    = '0;
      pih_d    = '0;
      pir_d    = '0;
      active_d = 1'b0;
      pend_d   = pend_set;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      cono_dly_q <= 1'b0;
      cmd_q      <= '0;
      lvl_q      <= '0;
      on_q       <= '0;
      gen_q      <= '0;
      pih_q      <= '0;
      pir_q      <= '0;
      pend_q     <= '0;
      prev_q     <= '0;
      active_q   <= 1'b0;
      req_q      <= 1'b0;
      req_lvl_q  <= '0;
    end else begin
      cono_dly_q <= cono_stb;
      cmd_q      <= cono_cmd;
      lvl_q      <= cono_lvl;
      on_q       <= on_d;
      gen_q      <= gen_d;
      pih_q      <= pih_d;
      pir_q      <= pir_d;
      pend_q     <= pend_d;
      prev_q     <= io_req;
      active_q   <= active_d;
      req_q      <= req_d;
      req_lvl_q  <= req_lvl_d;
    end
  end

  assign req      = req_q;
  assign req_lvl  = req_lvl_q;
  assign pih      = pih_q;
  assign on       = on_q;
  assign gen      = gen_q;
  assign active   = active_q;
  assign hold_lvl = hold_lvl_w;

endmodule

// File: tb/tb_pi_nlevel.sv
// Bench for pi_nlevel: directed scenarios on a 7-level and a 15-level instance,
// then randomized episodes on the 7-level one against a behavioural model.
module tb_pi_nlevel;

  logic clk, rst;

  logic        a_stb, a_dis, a_grant, a_dismiss;
  logic [6:0]  a_cmd, a_lvl, a_io;
  logic        a_req, a_active;
  logic [2:0]  a_req_lvl, a_hold;
  logic [6:0]  a_pih, a_on, a_gen;

  logic        b_stb, b_dis, b_grant, b_dismiss;
  logic [6:0]  b_cmd;
  logic [14:0] b_lvl, b_io;
  logic        b_req, b_active;
  logic [3:0]  b_req_lvl, b_hold;
  logic [14:0] b_pih, b_on, b_gen;

  int n_cmp = 0;
  int n_bad = 0;

  // Model of the 7-level instance's architectural state.
  logic [6:0] m_on, m_gen, m_pih, m_io;
  logic       m_act;

  pi_nlevel #(.NLEVELS(7), .EDGE_MASK(7'b0000001)) u_a (
    .clk(clk), .RESET(rst), .cono_stb(a_stb), .cono_cmd(a_cmd), .cono_lvl(a_lvl),
    .io_req(a_io), .pi_disable(a_dis), .req(a_req), .req_lvl(a_req_lvl),
    .grant(a_grant), .dismiss(a_dismiss), .pih(a_pih), .on(a_on), .gen(a_gen),
    .active(a_active), .hold_lvl(a_hold)
  );

  pi_nlevel #(.NLEVELS(15), .EDGE_MASK(15'h0)) u_b (
    .clk(clk), .RESET(rst), .cono_stb(b_stb), .cono_cmd(b_cmd), .cono_lvl(b_lvl),
    .io_req(b_io), .pi_disable(b_dis), .req(b_req), .req_lvl(b_req_lvl),
    .grant(b_grant), .dismiss(b_dismiss), .pih(b_pih), .on(b_on), .gen(b_gen),
    .active(b_active), .hold_lvl(b_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cmd_a(input logic [6:0] c, input logic [6:0] m);
    a_stb = 1'b1; a_cmd = c; a_lvl = m;
    @(negedge clk);
    a_stb = 1'b0; a_cmd = '0; a_lvl = '0;
  endtask

  task automatic cmd_b(input logic [6:0] c, input logic [14:0] m);
    b_stb = 1'b1; b_cmd = c; b_lvl = m;
    @(negedge clk);
    b_stb = 1'b0; b_cmd = '0; b_lvl = '0;
  endtask

  task automatic wait_req(input bit sel, input int bound, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (sel ? b_req : a_req) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic no_req(input int n, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (a_req) seen = 1'b1;
    end
  endtask

  task automatic pulse_a(input bit g, input bit d);
    a_grant = g; a_dismiss = d;
    @(negedge clk);
    a_grant = 1'b0; a_dismiss = 1'b0;
  endtask

  // Command semantics: sys_clr clears everything, set beats clear, act beats deact.
  task automatic m_cmd(input logic [6:0] c, input logic [6:0] m);
    if (c[6]) begin
      m_on = '0; m_gen = '0; m_pih = '0; m_act = 1'b0;
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (c[3] && m[i])      m_on[i] = 1'b1;
        else if (c[2] && m[i]) m_on[i] = 1'b0;
        if (c[4] && m[i])      m_gen[i] = 1'b1;
        else if (c[5] && m[i]) m_gen[i] = 1'b0;
      end
      if (c[0])      m_act = 1'b1;
      else if (c[1]) m_act = 1'b0;
    end
  endtask

  function automatic logic [31:0] lowest(input logic [6:0] v);
    for (int i = 0; i < 7; i++) if (v[i]) return 32'(i + 1);
    return 32'd0;
  endfunction

  // Highest-priority requesting level not shadowed by any held level at or above it.
  function automatic logic [31:0] exp_lvl();
    logic [6:0] en;
    en = m_act ? (m_gen | (m_on & m_io)) : 7'h00;
    for (int i = 0; i < 7; i++) begin
      if (m_pih[i]) return 32'd0;
      if (en[i]) return 32'(i + 1);
    end
    return 32'd0;
  endfunction

  task automatic m_dismiss();
    logic [31:0] h;
    h = lowest(m_pih);
    if (h != 0) m_pih[h - 1] = 1'b0;
  endtask

  initial begin
    bit          seen;
    logic [6:0]  c, m;
    logic [31:0] e;
    bit          dm;
    int          nd;

    rst = 1'b1;
    a_stb = 0; a_cmd = '0; a_lvl = '0; a_io = '0; a_dis = 0; a_grant = 0; a_dismiss = 0;
    b_stb = 0; b_cmd = '0; b_lvl = '0; b_io = '0; b_dis = 0; b_grant = 0; b_dismiss = 0;
    m_on = '0; m_gen = '0; m_pih = '0; m_io = '0; m_act = 1'b0;
    step(3);
    chk("rst_req", a_req, 0);
    chk("rst_req_lvl", a_req_lvl, 0);
    chk("rst_hold", a_hold, 0);
    chk("rst_pih_on_gen", {a_pih, a_on, a_gen}, 0);
    chk("rst_active", a_active, 0);
    chk("rst_b_req", b_req, 0);
    rst = 1'b0;
    step(2);

    // Basic request, latency and grant.
    cmd_a(7'h09, 7'h7F);
    step(1);
    chk("act_on", {a_active, a_on}, {1'b1, 7'h7F});
    a_io = 7'h04;
    wait_req(1'b0, 4, seen);
    chk("lat_lvl3", seen, 1);
    chk("req_lvl3", a_req_lvl, 3);
    pulse_a(1, 0);
    chk("pih_lvl3", a_pih, 7'h04);
    chk("hold_lvl3", a_hold, 3);
    chk("req_drop", a_req, 0);

    // Nesting: level 2 preempts, level 5 waits for both dismisses.
    a_io = 7'h16;
    wait_req(1'b0, 8, seen);
    chk("nest_seen", seen, 1);
    chk("nest_lvl2", a_req_lvl, 2);
    pulse_a(1, 0);
    chk("nest_pih", a_pih, 7'h06);
    chk("nest_hold", a_hold, 2);
    a_io = 7'h14;
    no_req(6, seen);
    chk("nest_block1", seen, 0);
    pulse_a(0, 1);
    chk("dis1_pih", a_pih, 7'h04);
    chk("dis1_hold", a_hold, 3);
    a_io = 7'h10;
    no_req(6, seen);
    chk("nest_block2", seen, 0);
    pulse_a(0, 1);
    chk("dis2_pih", a_pih, 7'h00);
    wait_req(1'b0, 8, seen);
    chk("lvl5_seen", seen, 1);
    chk("lvl5_lvl", a_req_lvl, 5);
    pulse_a(1, 0);
    chk("lvl5_pih", a_pih, 7'h10);
    a_io = 7'h00;
    step(5);
    pulse_a(0, 1);
    chk("lvl5_dis", a_pih, 7'h00);
    no_req(8, seen);
    chk("idle_quiet", seen, 0);

    // Edge-triggered level 1: one-cycle pulse is remembered until granted.
    a_io = 7'h01;
    step(1);
    a_io = 7'h00;
    wait_req(1'b0, 8, seen);
    chk("edge_seen", seen, 1);
    chk("edge_lvl1", a_req_lvl, 1);
    pulse_a(1, 0);
    chk("edge_pih", a_pih, 7'h01);
    pulse_a(0, 1);
    chk("edge_dis", a_pih, 7'h00);
    no_req(8, seen);
    chk("edge_norereq", seen, 0);
    pulse_a(1, 0);
    chk("grant_idle_ignored", a_pih, 7'h00);

    // sys_clr during a request aborts it and wipes all level state.
    a_io = 7'h20;
    wait_req(1'b0, 8, seen);
    chk("l6_lvl", a_req_lvl, 6);
    pulse_a(1, 0);
    chk("l6_pih", a_pih, 7'h20);
    a_io = 7'h00;
    cmd_a(7'h10, 7'h40);
    step(1);
    chk("gen_set", a_gen, 7'h40);
    a_io = 7'h08;
    wait_req(1'b0, 8, seen);
    chk("l4_seen", seen, 1);
    chk("l4_lvl", a_req_lvl, 4);
    cmd_a(7'h40, 7'h00);
    chk("sysclr_abort", a_req, 0);
    step(1);
    chk("sysclr_state", {a_active, a_on, a_gen, a_pih}, 0);
    a_io = 7'h00;

    // 15 levels: software request on the lowest level, grant with dismiss.
    cmd_b(7'h11, 15'h4000);
    wait_req(1'b1, 8, seen);
    chk("b15_seen", seen, 1);
    chk("b15_lvl", b_req_lvl, 15);
    b_grant = 1; b_dismiss = 1;
    step(1);
    b_grant = 0; b_dismiss = 0;
    chk("b15_pih", b_pih, 15'h4000);
    chk("b15_hold", b_hold, 15);
    cmd_b(7'h10, 15'h0004);
    wait_req(1'b1, 8, seen);
    chk("b3_lvl", b_req_lvl, 3);
    b_grant = 1; b_dismiss = 1;
    step(1);
    b_grant = 0; b_dismiss = 0;
    chk("b3_pih", b_pih, 15'h0004);
    chk("b3_hold", b_hold, 3);

    // Randomized episodes against the model (level 1 device line kept low).
    for (int ep = 0; ep < 40; ep++) begin
      a_dis = 1'b1;
      step(2);
      c = 7'($urandom) & 7'h3F;
      if ($urandom_range(0, 3) != 0) c[1] = 1'b0;
      m = 7'($urandom);
      m_io = 7'($urandom) & 7'h7E;
      a_io = m_io;
      cmd_a(c, m);
      m_cmd(c, m);
      step(5);
      chk("rnd_on", a_on, m_on);
      chk("rnd_gen", a_gen, m_gen);
      chk("rnd_act", a_active, m_act);
      a_dis = 1'b0;
      e = exp_lvl();
      if (e == 0) begin
        no_req(8, seen);
        chk("rnd_noreq", seen, 0);
      end else begin
        wait_req(1'b0, 8, seen);
        chk("rnd_seen", seen, 1);
        if (seen) begin
          chk("rnd_lvl", a_req_lvl, e);
          dm = ($urandom_range(0, 2) == 0);
          a_grant = 1'b1; a_dismiss = dm;
          if (dm) m_dismiss();
          m_pih[e - 1] = 1'b1;
          @(negedge clk);
          a_grant = 1'b0; a_dismiss = 1'b0; a_dis = 1'b1;
          chk("rnd_pih", a_pih, m_pih);
        end
      end
      a_dis = 1'b1;
      nd = $urandom_range(0, 2);
      for (int k = 0; k < nd; k++) begin
        pulse_a(0, 1);
        m_dismiss();
      end
      chk("rnd_pih2", a_pih, m_pih);
      chk("rnd_hold", a_hold, lowest(m_pih));
    end

    // Asynchronous reset mid-request, with a grant in the same cycle.
    a_dis = 1'b1;
    step(2);
    cmd_a(7'h40, 7'h00);
    cmd_a(7'h09, 7'h7F);
    a_io = 7'h08;
    step(5);
    a_dis = 1'b0;
    wait_req(1'b0, 8, seen);
    chk("ar_seen", seen, 1);
    a_grant = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("ar_req", a_req, 0);
    chk("ar_req_lvl", a_req_lvl, 0);
    chk("ar_hold", a_hold, 0);
    chk("ar_state", {a_active, a_on, a_gen, a_pih}, 0);
    chk("ar_b", {b_pih, b_gen, b_active}, 0);
    @(negedge clk);
    rst = 1'b0; a_grant = 1'b0; a_io = '0;
    step(2);
    chk("ar_grant_lost", a_pih, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
